booth_mul_div_sequencer: RTL and testbench
==========================================

// Module: booth_mul_div_sequencer
// PURPOSE
//  Multi-cycle sequencer for the ALU's MUL/DIV datapath. It accepts one signed
//  operation per start pulse. MUL runs radix-2 Booth recoding, one multiplier
//  bit per clock. DIV runs restoring division on magnitudes, then a sign fix.
//  Results land in the HI/LO pair for the register file. busy stalls the
//  control unit while an operation is in flight.
// PARAMETERS
//  WIDTH   32   operand width; hi/lo are each WIDTH bits; iteration count = WIDTH
// PORTS
//  clk           in   1      system clock, rising edge
//  clr_n         in   1      asynchronous reset, active low
//  start         in   1      begin operation; sampled only in IDLE
//  op            in   1      0 = MUL (signed), 1 = DIV (signed)
//  a             in   WIDTH  multiplier (MUL) / dividend (DIV)
//  b             in   WIDTH  multiplicand (MUL) / divisor (DIV)
//  busy          out  1      high from the cycle after start is accepted until done
//  done          out  1      one-cycle pulse; hi/lo valid from this cycle on
//  hi            out  WIDTH  MUL: product[2W-1:W]; DIV: remainder
//  lo            out  WIDTH  MUL: product[W-1:0];  DIV: quotient
//  div_by_zero   out  1      set with done when DIV with b==0; cleared on next start
// BEHAVIOUR
//  - Reset (clr_n=0, any time, incl. mid-operation): state=IDLE; busy=0, done=0,
//    hi=0, lo=0, div_by_zero=0; iteration counter=0; the in-flight op is discarded.
//  - FSM states: IDLE, LOAD, ITER, FIX, DONE.
//  - IDLE: start=1 -> LOAD. a, b and op are latched on that edge.
//    Operands may change afterwards without effect.
//  - LOAD: MUL -> acc=0, Q=a, q_-1=0.
//    DIV with b!=0 -> latch |a|, |b| and sign bits.
//    DIV with b==0 -> skip straight to DONE.
//    Otherwise go to ITER, counter=WIDTH-1.
//  - ITER: one step per cycle; the step after counter==0 moves to FIX.
//  - MUL step: {Q0,q_-1}=01 -> acc+=M; =10 -> acc-=M; 00/11 -> no-op.
//    Then arithmetic right shift of {acc,Q,q_-1} by one.
//    acc is WIDTH+1 bits so that M=-2^(W-1) does not overflow.
//  - DIV step: shift {R,Q} left one; trial R-|b|. If the result is >=0, keep it
//    and set Q0=1; otherwise restore R and set Q0=0.
//  - FIX: MUL -> hi/lo <= product.
//    DIV -> quotient negated if sign(a)^sign(b), remainder negated if sign(a).
//    Quotient truncates toward zero; the remainder takes the dividend's sign.
//    -2^(W-1) / -1 wraps: lo=0x80000000, hi=0, no flag.
//  - DIV by zero: hi=a, lo=all ones, div_by_zero=1.
//  - DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
//  - Latency: start edge at cycle 0 -> done at cycle WIDTH+3 (35 for WIDTH=32).
//    Div-by-zero: done at cycle 2.
//  - busy=1 in LOAD, ITER and FIX.
//  - start asserted while busy or in DONE is ignored; it is not queued.
//    Back-to-back: start in the cycle after done is accepted.
//  - hi/lo hold their last result until the FIX (or DONE) of the next op.
//    They never show partial values.
// CONFIGURATION
//  BOOTH_SEQ_DIVIDE_EN defined: DIV supported as described above.
//  Not defined: op is ignored and every operation is MUL.
//  div_by_zero stays tied to 0, and the DIV datapath and FIX sign logic are
//  not built.
// TESTING
//  1. MUL a=7, b=-3 -> done at cycle 35; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//  2. MUL a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
//  3. DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_by_zero=0.
//  4. DIV a=5, b=0 -> done at cycle 2; hi=5, lo=0xFFFFFFFF, div_by_zero=1.
//     Then MUL 3*4 -> flag clears; lo=12, hi=0.
//  5. DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
//     Compile without the macro: same stimulus -> MUL, hi=0, lo=0x80000000.
//  6. MUL 6*9, with start pulsed again at cycle 10 -> ignored, one done only,
//     lo=54. Repeat with clr_n low at cycle 20 -> all outputs 0 immediately;
//     a fresh start then yields a correct result.

Source files
------------

// File: rtl/booth_mul_div_sequencer.sv
// booth_mul_div_sequencer
// Multi-cycle signed MUL/DIV sequencer feeding the HI/LO register pair.
// MUL uses radix-2 Booth recoding, one multiplier bit per clock.
// DIV uses restoring division on operand magnitudes followed by a sign fix.
// Optional feature macro: BOOTH_SEQ_DIVIDE_EN (undefined: every operation is MUL,
// op is ignored and div_by_zero is tied low).
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; operands and op latched on the accepting edge
// LOAD   | initialise acc/Q/M (or magnitudes and signs); DIV by zero -> DONE
// ITER   | one Booth or restoring step per clock, WIDTH steps in total
// FIX    | copy product, or sign-corrected quotient/remainder, into hi/lo
// DONE   | one-cycle done pulse, busy low, back to IDLE
`timescale 1ns/1ps
module booth_mul_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH:0]   r_m;
    logic             r_qm1;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dbz;

    logic             w_div_op;
    logic             w_div_zero;
    logic             w_last_iter;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_mul_acc;
    logic [WIDTH-1:0] w_mul_q;
    logic [WIDTH:0]   w_step_acc;
    logic [WIDTH-1:0] w_step_q;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    assign w_last_iter = (r_cnt == '0);

    // Booth step: add/subtract M per {Q0, q_-1}, then arithmetic shift right
    always_comb begin
        w_mul_sum = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_mul_sum = r_acc + r_m;
            2'b10:   w_mul_sum = r_acc - r_m;
            default: w_mul_sum = r_acc;
        endcase
    end

    assign w_mul_acc = {w_mul_sum[WIDTH], w_mul_sum[WIDTH:1]};
    assign w_mul_q   = {w_mul_sum[0], r_q[WIDTH-1:1]};

`ifdef BOOTH_SEQ_DIVIDE_EN
    logic             r_op;
    logic             r_sa;
    logic             r_sb;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_rsh;
    logic [WIDTH+1:0] w_trial;
    logic [WIDTH:0]   w_div_acc;
    logic [WIDTH-1:0] w_div_q;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    assign w_div_op   = r_op;
    assign w_div_zero = r_op && (r_b == '0);

    // Magnitudes; -2^(W-1) maps onto itself, which is correct as unsigned
    assign w_abs_a = r_a[WIDTH-1] ? -r_a : r_a;
    assign w_abs_b = r_b[WIDTH-1] ? -r_b : r_b;

    // Restoring step: shift {R,Q} left, keep R-|b| only when it is non-negative
    assign w_rsh     = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_trial   = {1'b0, w_rsh} - {1'b0, r_m};
    assign w_div_acc = w_trial[WIDTH+1] ? w_rsh : w_trial[WIDTH:0];
    assign w_div_q   = {r_q[WIDTH-2:0], ~w_trial[WIDTH+1]};

    // Quotient truncates toward zero; remainder follows the dividend's sign
    assign w_quo = (r_sa ^ r_sb) ? -r_q : r_q;
    assign w_rem = r_sa ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

    // Operation select and operand signs for the divide path
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_op <= 1'b0;
            r_sa <= 1'b0;
            r_sb <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_op <= op;
            end
            if (r_state == S_LOAD) begin
                r_sa <= r_a[WIDTH-1];
                r_sb <= r_b[WIDTH-1];
            end
        end
    end
`else
    logic w_unused_op;
    assign w_unused_op = op;
    assign w_div_op    = 1'b0;
    assign w_div_zero  = 1'b0;
`endif

    // Per-iteration update and final result, selected by the latched operation
    always_comb begin
        w_step_acc = w_mul_acc;
        w_step_q   = w_mul_q;
        w_res_hi   = r_acc[WIDTH-1:0];
        w_res_lo   = r_q;
`ifdef BOOTH_SEQ_DIVIDE_EN
        if (w_div_op) begin
            w_step_acc = w_div_acc;
            w_step_q   = w_div_q;
            w_res_hi   = w_rem;
            w_res_lo   = w_quo;
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and Moore outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                busy        = 1'b1;
                w_state_nxt = w_div_zero ? S_DONE : S_ITER;
            end
            S_ITER: begin
                busy = 1'b1;
                if (w_last_iter) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                busy        = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration registers and the HI/LO result pair
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_q   <= '0;
            r_acc <= '0;
            r_m   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_dbz <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_dbz <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_div_zero) begin
                        r_hi  <= r_a;
                        r_lo  <= '1;
                        r_dbz <= 1'b1;
                    end else begin
                        r_acc <= '0;
                        r_qm1 <= 1'b0;
                        r_cnt <= CNT_LAST;
                        r_q   <= r_a;
                        r_m   <= {r_b[WIDTH-1], r_b};
`ifdef BOOTH_SEQ_DIVIDE_EN
                        if (r_op) begin
                            r_q <= w_abs_a;
                            r_m <= {1'b0, w_abs_b};
                        end
`endif
                    end
                end
                S_ITER: begin
                    r_acc <= w_step_acc;
                    r_q   <= w_step_q;
                    r_qm1 <= r_q[0];
                    if (!w_last_iter) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_FIX: begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
                default: begin
                end
            endcase
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_booth_mul_div_sequencer.sv
// Testbench for booth_mul_div_sequencer: directed vector table, hand-written
// multi-cycle sequences and randomized operations against an arithmetic model.
`timescale 1ns/1ps
module tb_booth_mul_div_sequencer;

    localparam int W = 32;
`ifdef BOOTH_SEQ_DIVIDE_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clr_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int errors = 0;
    int checks = 0;

    // Expected hi/lo from the previous completed operation
    logic [W-1:0] prev_hi = '0;
    logic [W-1:0] prev_lo = '0;

    booth_mul_div_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers
    function automatic void model(input logic m_op, input logic [W-1:0] m_a, input logic [W-1:0] m_b,
                                  output logic [W-1:0] m_hi, output logic [W-1:0] m_lo,
                                  output logic m_dbz, output int m_lat);
        longint sa, sb, p, q, r;
        sa = longint'($signed(m_a));
        sb = longint'($signed(m_b));
        m_dbz = 1'b0;
        m_lat = W + 3;
        if (m_op && DIV_EN) begin
            if (m_b == '0) begin
                m_hi  = m_a;
                m_lo  = '1;
                m_dbz = 1'b1;
                m_lat = 2;
            end else begin
                q = sa / sb;
                r = sa % sb;
                m_hi = r[W-1:0];
                m_lo = q[W-1:0];
            end
        end else begin
            p = sa * sb;
            m_hi = p[2*W-1:W];
            m_lo = p[W-1:0];
        end
    endfunction

    // Called #1 after a rising edge with the DUT idle; returns #1 after the
    // edge following done, so the next start lands in the cycle after done.
    task automatic do_op(input logic t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                         input bit poke, output logic [W-1:0] r_hi, output logic [W-1:0] r_lo,
                         output logic r_dbz, output int lat);
        int cyc;
        bit hold_ok;
        op = t_op;
        a = t_a;
        b = t_b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = ~t_op;
        a = $urandom;
        b = $urandom;
        chk("busy_in_load", busy, 1);
        chk("dbz_cleared_on_start", div_by_zero, 0);
        cyc = 1;
        hold_ok = 1'b1;
        while (!done && cyc < 80) begin
            if (hi !== prev_hi || lo !== prev_lo) hold_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: done not seen after %0d cycles, required within 80", cyc);
        end
        chk("busy_low_at_done", busy, 0);
        chk("hilo_hold_while_busy", hold_ok, 1);
        r_hi = hi;
        r_lo = lo;
        r_dbz = div_by_zero;
        lat = cyc;
        if (poke) begin
            start = 1'b1;
            op = 1'b0;
            a = 32'd100;
            b = 32'd100;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rh, rl, eh, el;
        logic rd, ed;
        int lat, elat, ndone;

        // Reset state
        clr_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        clr_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        // Directed vectors (op, a, b, hi, lo, dbz, latency)
        vecs[0] = '{1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 35};
        vecs[1] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 35};
        vecs[4] = '{1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 35};
        vecs[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 35};
        vecs[7] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 35};
        vecs[8] = '{1'b0, 32'hFFFFFFFF, 32'h80000000, 32'd0, 32'h80000000, 1'b0, 35};
`ifdef BOOTH_SEQ_DIVIDE_EN
        vecs[2]  = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35};
        vecs[3]  = '{1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 2};
        vecs[6]  = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 35};
        vecs[9]  = '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 35};
        vecs[10] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14, 1'b0, 35};
        vecs[11] = '{1'b1, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 35};
`else
        vecs[2]  = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0, 35};
        vecs[3]  = '{1'b1, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 35};
        vecs[6]  = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0, 35};
        vecs[9]  = '{1'b1, 32'd100, 32'd7, 32'd0, 32'd700, 1'b0, 35};
        vecs[10] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd0, 32'd700, 1'b0, 35};
        vecs[11] = '{1'b1, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 35};
`endif
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, rh, rl, rd, lat);
            chk($sformatf("vec%0d_hi", i), rh, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), rl, vecs[i].lo);
            chk($sformatf("vec%0d_dbz", i), rd, vecs[i].dbz);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            prev_hi = vecs[i].hi;
            prev_lo = vecs[i].lo;
        end

        // start during DONE must be ignored
        do_op(1'b0, 32'd2, 32'd3, 1'b1, rh, rl, rd, lat);
        chk("poke_lo", rl, 6);
        prev_hi = 0;
        prev_lo = 6;
        chk("start_in_done_ignored", busy, 0);
        @(posedge clk); #1;
        chk("start_in_done_ignored_2", busy, 0);
        chk("start_in_done_lo", lo, 6);

        // Second start mid-operation is ignored: exactly one done, 6*9
        op = 1'b0;
        a = 32'd6;
        b = 32'd9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        lat = 0;
        for (int c = 1; c <= 50; c++) begin
            if (done) begin
                ndone++;
                if (lat == 0) lat = c;
            end
            start = (c == 10);
            if (c == 10) begin
                a = 32'd2;
                b = 32'd2;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("restart_done_count", ndone, 1);
        chk("restart_latency", lat, 35);
        chk("restart_lo", lo, 54);
        chk("restart_hi", hi, 0);
        chk("restart_busy_after", busy, 0);

        // Asynchronous reset mid-operation clears everything immediately
        op = 1'b0;
        a = 32'd6;
        b = 32'd9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 20; c++) begin
            @(posedge clk); #1;
        end
        chk("midop_busy", busy, 1);
        #2;
        clr_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_lo", lo, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_dbz", div_by_zero, 0);
        @(posedge clk); #1;
        clr_n = 1'b1;
        prev_hi = 0;
        prev_lo = 0;
        @(posedge clk); #1;
        do_op(1'b0, 32'd6, 32'd9, 1'b0, rh, rl, rd, lat);
        chk("after_rst_lo", rl, 54);
        chk("after_rst_hi", rh, 0);
        chk("after_rst_latency", lat, 35);
        prev_hi = 0;
        prev_lo = 54;

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic         r_op;
            logic [W-1:0] r_a, r_b;
            r_op = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: r_a = '0;
                1: r_a = '1;
                2: r_a = 32'h80000000;
                3: r_a = 32'($urandom_range(0, 15));
                default: r_a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: r_b = '0;
                1: r_b = '1;
                2: r_b = 32'h80000000;
                3: r_b = 32'($urandom_range(1, 15));
                default: r_b = $urandom;
            endcase
            model(r_op, r_a, r_b, eh, el, ed, elat);
            do_op(r_op, r_a, r_b, 1'b0, rh, rl, rd, lat);
            chk($sformatf("rnd%0d_hi op=%0d a=%h b=%h", i, r_op, r_a, r_b), rh, eh);
            chk($sformatf("rnd%0d_lo op=%0d a=%h b=%h", i, r_op, r_a, r_b), rl, el);
            chk($sformatf("rnd%0d_dbz", i), rd, ed);
            chk($sformatf("rnd%0d_latency", i), lat, elat);
            prev_hi = eh;
            prev_lo = el;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
